// File: rtl/hazard_unit_mc_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard unit (slave).
// Carries the register tags, stage controls, memory handshake and the resulting stall/flush set.
interface hazard_unit_mc_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
);
    logic [REG_AW-1:0] Rs1D;
    logic [REG_AW-1:0] Rs2D;
    logic [REG_AW-1:0] Rs1E;
    logic [REG_AW-1:0] Rs2E;
    logic [REG_AW-1:0] RdE;
    logic [REG_AW-1:0] RdM;
    logic [REG_AW-1:0] RdW;
    logic              RegWriteM;
    logic              RegWriteW;
    logic              ResultSrcE0;
    logic              PCSrcE;
    logic              McStartE;
    logic              MemAccessM;
    logic              DMemReadyM;

    logic [1:0]        ForwardAE;
    logic [1:0]        ForwardBE;
    logic              StallF;
    logic              StallD;
    logic              StallE;
    logic              StallM;
    logic              FlushD;
    logic              FlushE;
    logic              FlushW;
    logic              McBusy;
    logic              McDoneE;
    logic              MemErr;
    logic [CNT_W-1:0]  StallCount;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
               ResultSrcE0, PCSrcE, McStartE, MemAccessM, DMemReadyM,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE,
               FlushW, McBusy, McDoneE, MemErr, StallCount
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
               ResultSrcE0, PCSrcE, McStartE, MemAccessM, DMemReadyM,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE,
               FlushW, McBusy, McDoneE, MemErr, StallCount
    );
endinterface

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage pipe: forwarding, load-use stall, branch flush, multi-cycle
// execute hold, data-memory wait with sticky timeout, and a saturating stall counter.
module hazard_unit_mc #(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned MC_LATENCY  = 4,
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input logic              clk,
    input logic              reset,
    hazard_unit_mc_if.slave  hz
);
    localparam int unsigned CW = $clog2(MC_LATENCY + 1);
    localparam int unsigned WW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {StRun, StMcBusy} state_e;

    state_e           r_state;
    state_e           w_state_d;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_d;
    logic [WW-1:0]    r_wait_cnt;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_mem_wait;
    logic             w_mc_hold;
    logic             w_mc_done;
    logic             w_lw_stall;

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
        if (src != '0 && src == hz.RdM && hz.RegWriteM) begin
            return 2'b10;
        end else if (src != '0 && src == hz.RdW && hz.RegWriteW) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign hz.ForwardAE = fwd_sel(hz.Rs1E);
    assign hz.ForwardBE = fwd_sel(hz.Rs2E);

    assign w_mem_wait = hz.MemAccessM & ~hz.DMemReadyM;

    // Memory wait freezes the FSM so a multi-cycle op keeps its remaining E cycles.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_mc_hold = 1'b0;
        w_mc_done = 1'b0;
        if (!w_mem_wait) begin
            unique case (r_state)
                StRun: begin
                    if (MC_LATENCY > 1) begin
                        if (hz.McStartE) begin
                            w_mc_hold = 1'b1;
                            w_cnt_d   = CW'(MC_LATENCY - 2);
                            w_state_d = StMcBusy;
                        end
                    end else begin
                        w_mc_done = hz.McStartE;
                    end
                end
                StMcBusy: begin
                    if (r_cnt != '0) begin
                        w_mc_hold = 1'b1;
                        w_cnt_d   = r_cnt - 1'b1;
                    end else begin
                        w_mc_done = 1'b1;
                        w_state_d = StRun;
                    end
                end
                default: w_state_d = StRun;
            endcase
        end
    end

    assign w_lw_stall = hz.ResultSrcE0 & (hz.RdE != '0) &
                        ((hz.Rs1D == hz.RdE) | (hz.Rs2D == hz.RdE)) &
                        ~w_mem_wait & ~w_mc_hold;

    always_comb begin
        hz.StallF = w_lw_stall;
        hz.StallD = w_lw_stall;
        hz.StallE = 1'b0;
        hz.StallM = 1'b0;
        hz.FlushD = hz.PCSrcE;
        hz.FlushE = w_lw_stall | hz.PCSrcE;
        hz.FlushW = 1'b0;
        if (w_mem_wait) begin
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.StallE = 1'b1;
            hz.StallM = 1'b1;
            hz.FlushD = 1'b0;
            hz.FlushE = 1'b0;
            hz.FlushW = 1'b1;
        end else if (w_mc_hold) begin
            // M keeps running; the caller gates its write with StallE & ~StallM.
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.StallE = 1'b1;
            hz.FlushD = 1'b0;
            hz.FlushE = 1'b0;
        end
    end

    assign hz.McBusy     = (r_state == StMcBusy);
    assign hz.McDoneE    = w_mc_done;
    assign hz.MemErr     = r_mem_err;
    assign hz.StallCount = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StRun;
            r_cnt       <= '0;
            r_wait_cnt  <= '0;
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (w_mem_wait) begin
                if (r_wait_cnt == WW'(MEM_TIMEOUT - 1)) begin
                    r_mem_err <= 1'b1;
                end else begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end
            if (hz.StallF && r_stall_cnt != {CNT_W{1'b1}}) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: directed scenarios then random traffic, each cycle's expected
// outputs predicted by an occupancy/run-length reference model and checked by a queue monitor.
module tb_hazard_unit_mc;
    localparam int unsigned REG_AW      = 5;
    localparam int unsigned MC_LATENCY  = 4;
    localparam int unsigned MEM_TIMEOUT = 4;
    localparam int unsigned CNT_W       = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_unit_mc_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hz ();

    hazard_unit_mc #(
        .REG_AW(REG_AW),
        .MC_LATENCY(MC_LATENCY),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .hz(hz)
    );

    typedef struct {
        logic rst;
        logic [REG_AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic rwm, rww, rsrc, pcsrc, mcstart, memacc, ready;
    } stim_t;

    typedef struct {
        bit chk_comb;
        int fa, fb, sf, sd, se, sm, fd, fe, fw, done;
        int busy, err, scnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: E cycles already spent by the current long op, wait run length, etc.
    int occ  = 0;
    int wrun = 0;
    int err  = 0;
    int scnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int fwd(input int src, input int rdm, input int rwm, input int rdw,
                               input int rww);
        if (src != 0 && src == rdm && rwm != 0) return 2;
        if (src != 0 && src == rdw && rww != 0) return 1;
        return 0;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        s.ready = 1'b1;
        return s;
    endfunction

    task automatic cyc(input stim_t s);
        exp_t e;
        int   mw, hold, done, lw, n;
        @(posedge clk);
        #1;
        reset          = s.rst;
        hz.Rs1D        = s.rs1d;
        hz.Rs2D        = s.rs2d;
        hz.Rs1E        = s.rs1e;
        hz.Rs2E        = s.rs2e;
        hz.RdE         = s.rde;
        hz.RdM         = s.rdm;
        hz.RdW         = s.rdw;
        hz.RegWriteM   = s.rwm;
        hz.RegWriteW   = s.rww;
        hz.ResultSrcE0 = s.rsrc;
        hz.PCSrcE      = s.pcsrc;
        hz.McStartE    = s.mcstart;
        hz.MemAccessM  = s.memacc;
        hz.DMemReadyM  = s.ready;

        mw   = (s.memacc && !s.ready) ? 1 : 0;
        hold = 0;
        done = 0;
        n    = occ;
        if (mw == 0 && (occ > 0 || (s.mcstart && MC_LATENCY > 1))) begin
            n    = occ + 1;
            done = (n == MC_LATENCY) ? 1 : 0;
            hold = 1 - done;
        end
        if (MC_LATENCY == 1) done = (s.mcstart && mw == 0) ? 1 : 0;
        lw = (s.rsrc && s.rde != 0 && (s.rs1d == s.rde || s.rs2d == s.rde) && mw == 0 &&
              hold == 0) ? 1 : 0;

        e.chk_comb = !s.rst;
        e.fa   = fwd(int'(s.rs1e), int'(s.rdm), int'(s.rwm), int'(s.rdw), int'(s.rww));
        e.fb   = fwd(int'(s.rs2e), int'(s.rdm), int'(s.rwm), int'(s.rdw), int'(s.rww));
        e.done = done;
        e.busy = (occ > 0) ? 1 : 0;
        e.err  = err;
        e.scnt = scnt;
        if (mw != 0) begin
            e.sf = 1; e.sd = 1; e.se = 1; e.sm = 1; e.fd = 0; e.fe = 0; e.fw = 1;
        end else if (hold != 0) begin
            e.sf = 1; e.sd = 1; e.se = 1; e.sm = 0; e.fd = 0; e.fe = 0; e.fw = 0;
        end else begin
            e.sf = lw; e.sd = lw; e.se = 0; e.sm = 0;
            e.fd = int'(s.pcsrc); e.fe = (lw != 0 || s.pcsrc) ? 1 : 0; e.fw = 0;
        end
        q.push_back(e);

        if (s.rst) begin
            occ = 0; wrun = 0; err = 0; scnt = 0;
        end else begin
            if (mw == 0 && (occ > 0 || (s.mcstart && MC_LATENCY > 1))) occ = (done != 0) ? 0 : n;
            if (mw != 0) begin
                if (wrun >= MEM_TIMEOUT - 1) err = 1;
                wrun++;
            end else begin
                wrun = 0;
            end
            if (e.sf != 0 && scnt < (1 << CNT_W) - 1) scnt++;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("McBusy", 32'(hz.McBusy), e.busy);
                chk("MemErr", 32'(hz.MemErr), e.err);
                chk("StallCount", 32'(hz.StallCount), e.scnt);
                if (e.chk_comb) begin
                    chk("ForwardAE", 32'(hz.ForwardAE), e.fa);
                    chk("ForwardBE", 32'(hz.ForwardBE), e.fb);
                    chk("StallF", 32'(hz.StallF), e.sf);
                    chk("StallD", 32'(hz.StallD), e.sd);
                    chk("StallE", 32'(hz.StallE), e.se);
                    chk("StallM", 32'(hz.StallM), e.sm);
                    chk("FlushD", 32'(hz.FlushD), e.fd);
                    chk("FlushE", 32'(hz.FlushE), e.fe);
                    chk("FlushW", 32'(hz.FlushW), e.fw);
                    chk("McDoneE", 32'(hz.McDoneE), e.done);
                end
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        reset          = 1'b1;
        hz.Rs1D        = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0;
        hz.RdE         = '0; hz.RdM  = '0; hz.RdW  = '0;
        hz.RegWriteM   = 1'b0; hz.RegWriteW = 1'b0; hz.ResultSrcE0 = 1'b0;
        hz.PCSrcE      = 1'b0; hz.McStartE  = 1'b0; hz.MemAccessM  = 1'b0;
        hz.DMemReadyM  = 1'b1;
        repeat (2) @(posedge clk);

        // Reset state, then forwarding with M over W priority and x0 suppression.
        cyc(idle());
        s = idle(); s.rs1e = 5; s.rdm = 5; s.rwm = 1; s.rdw = 5; s.rww = 1; s.rs2e = 5;
        cyc(s);
        s.rs1e = 0; s.rwm = 0;
        cyc(s);
        // Load-use on Rs2D, then a load to x0 that must not stall.
        s = idle(); s.rsrc = 1; s.rde = 7; s.rs2d = 7; s.pcsrc = 1;
        cyc(s);
        s = idle(); s.rsrc = 1; s.rde = 0; s.rs1d = 0;
        cyc(s);
        // Multi-cycle op for its full latency.
        s = idle(); s.mcstart = 1; s.pcsrc = 1;
        repeat (MC_LATENCY) cyc(s);
        cyc(idle());
        // Memory wait in the middle of a multi-cycle op.
        s = idle(); s.mcstart = 1;
        cyc(s);
        s.memacc = 1; s.ready = 0;
        repeat (3) cyc(s);
        s.memacc = 0; s.ready = 1;
        repeat (MC_LATENCY) cyc(s);
        // Timeout: six wait cycles, sticky error, then reset clears it.
        s = idle(); s.memacc = 1; s.ready = 0;
        repeat (6) cyc(s);
        repeat (2) cyc(idle());
        s = idle(); s.rst = 1;
        cyc(s);
        cyc(idle());
        // Counter saturation under a persistent load-use stall.
        s = idle(); s.rsrc = 1; s.rde = 3; s.rs1d = 3;
        repeat (10) cyc(s);
        // Reset while busy.
        s = idle(); s.mcstart = 1;
        repeat (2) cyc(s);
        s.rst = 1;
        cyc(s);
        cyc(idle());

        for (int i = 0; i < 3000; i++) begin
            s.rst     = ($urandom_range(0, 49) == 0);
            s.rs1d    = REG_AW'($urandom_range(0, 3));
            s.rs2d    = REG_AW'($urandom_range(0, 3));
            s.rs1e    = REG_AW'($urandom_range(0, 3));
            s.rs2e    = REG_AW'($urandom_range(0, 3));
            s.rde     = REG_AW'($urandom_range(0, 3));
            s.rdm     = REG_AW'($urandom_range(0, 3));
            s.rdw     = REG_AW'($urandom_range(0, 3));
            s.rwm     = 1'($urandom_range(0, 1));
            s.rww     = 1'($urandom_range(0, 1));
            s.rsrc    = 1'($urandom_range(0, 1));
            s.pcsrc   = ($urandom_range(0, 4) == 0);
            s.mcstart = ($urandom_range(0, 3) == 0);
            s.memacc  = ($urandom_range(0, 2) == 0);
            s.ready   = ($urandom_range(0, 2) != 0);
            cyc(s);
        end

        repeat (4) @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
